// File: rtl/perf_mon_pkg.sv
// perf_mon_pkg: shared states and index constants for the pipeline performance monitor
package perf_mon_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    localparam int IDX_CYCLE  = 0;
    localparam int EVT_STALL  = 0;
    localparam int EVT_FLUSH  = 1;
    localparam int EVT_RETIRE = 2;
    localparam int EVT_BRANCH = 3;

endpackage

// File: rtl/perf_mon_counter.sv
// perf_mon_counter: saturating counter with clear and sticky overflow flag
module perf_mon_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic [W-1:0] nxt,
    output logic         ovf
);

    assign nxt = (inc && cnt != '1) ? cnt + W'(1) : cnt;

    // count up, hold at all-ones and remember that an increment was lost
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= nxt;
            if (inc && cnt == '1) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: cycle/event counters with cycle limit and indexed read port;
// shadow snapshot bank enabled by PERF_MON_SNAPSHOT_EN
module perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 32,
    parameter int SEL_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               clear_i,
    input  logic [CNT_W-1:0]   limit_i,
    input  logic               snap_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic               done_o,
    output logic [NUM_EVT:0]   ovf_o
);

    state_t                      state;
    logic                        cnt_en;
    logic                        hit;
    logic [NUM_EVT:0]            inc;
    logic [NUM_EVT:0][CNT_W-1:0] cnt;
    logic [NUM_EVT:0][CNT_W-1:0] nxt;
    logic [NUM_EVT:0][CNT_W-1:0] src;
    logic [CNT_W-1:0]            rd_mux;

    assign cnt_en  = state == RUN && start_i;
    assign hit     = limit_i != '0 && cnt[IDX_CYCLE] >= limit_i - CNT_W'(1);
    assign inc     = {evt_i & {NUM_EVT{cnt_en}}, cnt_en};
    assign cycle_o = cnt[IDX_CYCLE];
    assign done_o  = state == DONE;

    // run-control FSM; the limit is checked on the counted edge so done lands with the final count
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) state <= IDLE;
        else if (state == RUN) state <= !start_i ? HOLD : hit ? DONE : RUN;
        else if (state != DONE && start_i) state <= RUN;
    end

    for (genvar k = 0; k <= NUM_EVT; k++) begin : g_cnt
        perf_mon_counter #(.W(CNT_W)) u_cnt (
            .clk (clk_i),
            .rst (rst_i),
            .clr (clear_i),
            .inc (inc[k]),
            .cnt (cnt[k]),
            .nxt (nxt[k]),
            .ovf (ovf_o[k])
        );
    end

`ifdef PERF_MON_SNAPSHOT_EN
    logic [NUM_EVT:0][CNT_W-1:0] shadow;

    // snapshot takes the post-edge counter values so the capturing edge's increments are included
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) shadow <= '0;
        else if (snap_i) shadow <= nxt;
    end

    assign src = shadow;
`else
    logic unused_snap;

    assign unused_snap = ^{snap_i, nxt};
    assign src = cnt;
`endif

    // select the addressed counter; out-of-range indices read as zero
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k <= NUM_EVT; k++) rd_mux = rd_sel_i == SEL_W'(k) ? src[k] : rd_mux;
    end

    // registered read data
    always_ff @(posedge clk_i) begin
        rd_data_o <= rst_i ? '0 : rd_mux;
    end

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: randomized scoreboard bench for perf_monitor against a behavioural model
module tb_perf_monitor;

    localparam int NE = 4;
    localparam int CW = 6;
    localparam int SW = 4;
    localparam longint MAXV = (longint'(1) << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, start, clear, snap;
    logic [NE-1:0] evt;
    logic [CW-1:0] limit;
    logic [SW-1:0] sel;
    logic [CW-1:0] rd_data, cycle;
    logic          done;
    logic [NE:0]   ovf;

    always #5 clk = ~clk;

    perf_monitor #(.NUM_EVT(NE), .CNT_W(CW), .SEL_W(SW)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .evt_i     (evt),
        .clear_i   (clear),
        .limit_i   (limit),
        .snap_i    (snap),
        .rd_sel_i  (sel),
        .rd_data_o (rd_data),
        .cycle_o   (cycle),
        .done_o    (done),
        .ovf_o     (ovf)
    );

    typedef struct {
        logic [CW-1:0] rd;
        logic [CW-1:0] cyc;
        logic          done;
        logic [NE:0]   ovf;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    longint m_c[NE+1];
    longint m_sh[NE+1];
    bit     m_ovf[NE+1];
    int     m_st;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    // reference model: m_st 0=idle 1=run 2=hold 3=done, applied once per clock edge
    function automatic void model();
        longint rdv;
        exp_t   x;
        rdv = 0;
        if (sel <= NE) begin
`ifdef PERF_MON_SNAPSHOT_EN
            rdv = m_sh[sel];
`else
            rdv = m_c[sel];
`endif
        end
        if (rst || clear) begin
            for (int k = 0; k <= NE; k++) begin
                m_c[k] = 0;
                m_sh[k] = 0;
                m_ovf[k] = 0;
            end
            m_st = 0;
            if (rst) rdv = 0;
        end else begin
            if (m_st == 1 && start) begin
                for (int k = 0; k <= NE; k++) begin
                    if (k == 0 ? 1'b1 : evt[k-1]) begin
                        if (m_c[k] == MAXV) m_ovf[k] = 1;
                        else m_c[k]++;
                    end
                end
                if (limit != 0 && m_c[0] >= longint'(limit)) m_st = 3;
            end else if (m_st == 1) m_st = 2;
            else if (m_st != 3 && start) m_st = 1;
`ifdef PERF_MON_SNAPSHOT_EN
            if (snap) for (int k = 0; k <= NE; k++) m_sh[k] = m_c[k];
`endif
        end
        x.rd = rdv[CW-1:0];
        x.cyc = m_c[0][CW-1:0];
        x.done = m_st == 3;
        for (int k = 0; k <= NE; k++) x.ovf[k] = m_ovf[k];
        q.push_back(x);
    endfunction

    // monitor: every edge yields one output set, compared away from the edge
    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("rd_data", 64'(rd_data), 64'(x.rd));
            chk("cycle", 64'(cycle), 64'(x.cyc));
            chk("done", 64'(done), 64'(x.done));
            chk("ovf", 64'(ovf), 64'(x.ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        model();
        #1;
    endtask

    task automatic idle_in();
        rst = 0; start = 0; clear = 0; snap = 0; evt = '0;
    endtask

    initial begin
        idle_in();
        rst = 1; limit = '0; sel = '0;
        tick(); tick();
        rst = 0;
        chk("reset_cycle", 64'(cycle), 0);
        chk("reset_rd", 64'(rd_data), 0);
        // limit 10, channel 0 strobed on odd counted cycles
        limit = 10; start = 1; sel = 1;
        for (int i = 0; i < 14; i++) begin
            evt = {3'b000, 1'(i % 2)};
            tick();
        end
        evt = '0;
        tick();
        chk("limit_cycle", 64'(cycle), 10);
        chk("limit_done", 64'(done), 1);
        chk("limit_ch0", 64'(rd_data), 5);
        // clear with events on the same edge while running
        clear = 1; evt = '1;
        tick();
        clear = 0; evt = '0; limit = 0;
        tick(); tick(); tick();
        evt = '1; clear = 1;
        tick();
        clear = 0; evt = '0; start = 0;
        chk("clear_cycle", 64'(cycle), 0);
        chk("clear_ovf", 64'(ovf), 0);
        chk("clear_done", 64'(done), 0);
        // saturation of channel 1
        start = 1; evt = 4'b0010; sel = 2;
        repeat (70) tick();
        evt = '0; start = 0;
        tick();
        chk("sat_ch1", 64'(rd_data), MAXV);
        chk("sat_ovf2", 64'(ovf[2]), 1);
        chk("sat_ovf0", 64'(ovf[0]), 1);
        clear = 1;
        tick();
        clear = 0;
        tick();
        chk("sat_clr_rd", 64'(rd_data), 0);
        chk("sat_clr_ovf", 64'(ovf), 0);
        sel = SW'(NE + 1);
        tick();
        chk("sel_oob", 64'(rd_data), 0);
        // start toggling: 8 counted cycles, no done
        start = 1;
        repeat (6) tick();
        start = 0;
        tick();
        start = 1;
        repeat (4) tick();
        start = 0;
        tick();
        chk("toggle_cycle", 64'(cycle), 8);
        chk("toggle_done", 64'(done), 0);
        // snapshot at counted cycle 7 then 5 more
        clear = 1;
        tick();
        clear = 0; start = 1; sel = 0;
        tick();
        for (int i = 1; i <= 12; i++) begin
            snap = i == 7;
            tick();
        end
        snap = 0; start = 0;
        tick();
`ifdef PERF_MON_SNAPSHOT_EN
        chk("snap_read", 64'(rd_data), 7);
`else
        chk("snap_read", 64'(rd_data), 12);
`endif
        // reset mid-run
        start = 1; evt = '1;
        repeat (5) tick();
        rst = 1;
        tick();
        rst = 0;
        chk("rst_rd", 64'(rd_data), 0);
        chk("rst_cycle", 64'(cycle), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_ovf", 64'(ovf), 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(199) == 0;
            clear = $urandom_range(39) == 0;
            start = $urandom_range(9) < 8;
            snap = $urandom_range(9) == 0;
            evt = NE'($urandom);
            sel = SW'($urandom);
            if ($urandom_range(49) == 0) limit = $urandom_range(1) ? CW'($urandom_range(40)) : '0;
            tick();
        end
        idle_in();
        tick();
        repeat (5) begin
            if (q.size() != 0) @(negedge clk);
        end
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
